// File: rtl/firmware_loader.sv
// Boot sequencer: packs 16-bit firmware halfwords from spi_mm into 32-bit program RAM words,
// then flushes any odd halfword, hands the RAM port to the CPU and releases CPU reset.
module firmware_loader #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              firm_wr,
  input  logic [15:0]       firm_data,
  output logic              firm_ack,
  input  logic              cpu_start,
  output logic              cpu_start_ack,
  output logic              mem_wr,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_owner,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_overflow
);

  localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   WORDS_MAX = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {LOAD, WRITE, FLUSH, RUN} state_t;

  state_t              state, state_nxt;
  logic                half, half_nxt;
  logic                firm_ack_nxt, cpu_start_ack_nxt, mem_wr_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [31:0]         mem_wr_data_nxt;
  logic                mem_owner_nxt, cpu_reset_nxt, load_overflow_nxt;
  logic [ADDR_W:0]     words_loaded_nxt;

  // A request held high during its own ack pulse must not be taken twice.
  logic firm_seen, start_seen, mem_accept, full;
  assign firm_seen  = firm_wr & ~firm_ack;
  assign start_seen = cpu_start & ~cpu_start_ack;
  assign mem_accept = mem_wr & mem_wr_ready;
  assign full       = (words_loaded == WORDS_MAX);

  always_comb begin
    state_nxt         = state;
    half_nxt          = half;
    firm_ack_nxt      = 1'b0;
    cpu_start_ack_nxt = 1'b0;
    mem_wr_nxt        = mem_wr;
    mem_addr_nxt      = mem_addr;
    mem_wr_data_nxt   = mem_wr_data;
    mem_owner_nxt     = mem_owner;
    cpu_reset_nxt     = cpu_reset;
    words_loaded_nxt  = words_loaded;
    load_overflow_nxt = load_overflow;
    case (state)
      LOAD: begin
        if (firm_seen) begin
          if (full) begin
            firm_ack_nxt      = 1'b1;
            load_overflow_nxt = 1'b1;
          end else if (!half) begin
            mem_wr_data_nxt[15:0] = firm_data;
            half_nxt              = 1'b1;
            firm_ack_nxt          = 1'b1;
          end else begin
            // Second halfword stays unacked until the RAM takes the word.
            mem_wr_data_nxt[31:16] = firm_data;
            mem_wr_nxt             = 1'b1;
            state_nxt              = WRITE;
          end
        end else if (start_seen) begin
          if (half) begin
            mem_wr_data_nxt[31:16] = 16'h0000;
            mem_wr_nxt             = 1'b1;
            state_nxt              = FLUSH;
          end else begin
            cpu_start_ack_nxt = 1'b1;
            mem_owner_nxt     = 1'b1;
            cpu_reset_nxt     = 1'b0;
            state_nxt         = RUN;
          end
        end
      end
      WRITE, FLUSH: begin
        if (mem_accept) begin
          mem_wr_nxt       = 1'b0;
          mem_addr_nxt     = mem_addr + ADDR_W'(1);
          words_loaded_nxt = words_loaded + (ADDR_W+1)'(1);
          half_nxt         = 1'b0;
          if (state == WRITE) begin
            firm_ack_nxt = 1'b1;
            state_nxt    = LOAD;
          end else begin
            cpu_start_ack_nxt = 1'b1;
            mem_owner_nxt     = 1'b1;
            cpu_reset_nxt     = 1'b0;
            state_nxt         = RUN;
          end
        end
      end
      RUN: begin
        // Terminal: late requests are acknowledged and ignored.
        firm_ack_nxt      = firm_seen;
        cpu_start_ack_nxt = start_seen;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      half          <= 1'b0;
      firm_ack      <= 1'b0;
      cpu_start_ack <= 1'b0;
      mem_wr        <= 1'b0;
      mem_addr      <= ADDR_RST;
      mem_wr_data   <= 32'h0;
      mem_owner     <= 1'b0;
      cpu_reset     <= 1'b1;
      words_loaded  <= '0;
      load_overflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      half          <= half_nxt;
      firm_ack      <= firm_ack_nxt;
      cpu_start_ack <= cpu_start_ack_nxt;
      mem_wr        <= mem_wr_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wr_data   <= mem_wr_data_nxt;
      mem_owner     <= mem_owner_nxt;
      cpu_reset     <= cpu_reset_nxt;
      words_loaded  <= words_loaded_nxt;
      load_overflow <= load_overflow_nxt;
    end
  end

endmodule
